// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store controller in front of a 256x8
// byte RAM with a MOC handshake. Doublewords are split into two word accesses
// (high word at the lower address). Optional Moc timeout: `define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Rw,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [63:0]       WData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [63:0]       RData,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemDataIn,
  output logic [1:0]        MemMode,
  input  logic [31:0]       MemDataOut,
  input  logic              Moc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              half2_q, half2_d;
  logic              err_q, err_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [63:0]       rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(MOC_TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  logic        misaligned;
  logic        dword_first;
  logic [31:0] store_word;
  logic [63:0] load_fmt;

  // Alignment check on the incoming request
  always_comb begin
    misaligned = 1'b0;
    case (Size)
      2'b01:   misaligned = Addr[0];
      2'b10:   misaligned = (Addr[1:0] != 2'b00);
      2'b11:   misaligned = (Addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  assign dword_first = (size_q == 2'b11) && !half2_q;

  // Store data lane selection; unused bits forced to zero
  always_comb begin
    store_word = '0;
    case (size_q)
      2'b00:   store_word = {24'h0, wdata_q[7:0]};
      2'b01:   store_word = {16'h0, wdata_q[15:0]};
      2'b10:   store_word = wdata_q[31:0];
      default: store_word = half2_q ? wdata_q[31:0] : wdata_q[63:32];
    endcase
  end

  // Load result extension/assembly from the captured word(s)
  always_comb begin
    load_fmt = '0;
    case (size_q)
      2'b00:   load_fmt = {{56{signed_q & lo_q[7]}},  lo_q[7:0]};
      2'b01:   load_fmt = {{48{signed_q & lo_q[15]}}, lo_q[15:0]};
      2'b10:   load_fmt = {{32{signed_q & lo_q[31]}}, lo_q};
      default: load_fmt = {hi_q, lo_q};
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b1;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      half2_q  <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      half2_q  <= half2_d;
      err_q    <= err_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Next-state logic and RAM-side outputs
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    half2_d  = half2_q;
    err_d    = err_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    Busy         = (state_q != S_IDLE);
    Done         = 1'b0;
    Err          = 1'b0;
    MemEnable    = 1'b0;
    MemReadWrite = 1'b1;
    MemAddress   = '0;
    MemDataIn    = '0;
    MemMode      = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          rw_d     = Rw;
          size_d   = Size;
          signed_d = Signed;
          addr_d   = Addr;
          wdata_d  = WData;
          half2_d  = 1'b0;
          err_d    = misaligned;
          state_d  = misaligned ? S_FINISH : S_ACCESS;
`ifdef MEM_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end

      S_ACCESS: begin
        MemEnable    = 1'b1;
        MemReadWrite = rw_q;
        MemAddress   = addr_q;
        MemMode      = (size_q == 2'b11) ? 2'b10 : size_q;
        if (!rw_q) MemDataIn = store_word;
        if (Moc) begin
          if (rw_q) begin
            if (dword_first) hi_d = MemDataOut;
            else             lo_d = MemDataOut;
          end
          state_d = S_RELEASE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TMO_W'(MOC_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      S_RELEASE: begin
        if (!Moc) begin
          if (dword_first) begin
            half2_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(4);
            state_d = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            if (rw_q) rdata_d = load_fmt;
            state_d = S_FINISH;
          end
        end
      end

      default: begin
        Done    = 1'b1;
        Err     = err_q;
        state_d = S_IDLE;
      end
    endcase
  end

  assign RData = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian 256x8 RAM model that
// answers each enabled cycle with Moc, optionally holding Moc into RELEASE.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Rw = 1'b1;
  logic [1:0]  Size = 2'b00;
  logic        Signed = 1'b0;
  logic [7:0]  Addr = 8'h00;
  logic [63:0] WData = '0;
  logic        Busy, Done, Err;
  logic [63:0] RData;
  logic        MemEnable, MemReadWrite;
  logic [7:0]  MemAddress;
  logic [31:0] MemDataIn;
  logic [1:0]  MemMode;
  logic [31:0] MemDataOut = '0;
  logic        Moc = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.ADDR_W(8), .MOC_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Rw(Rw), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .Err(Err), .RData(RData),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .MemMode(MemMode), .MemDataOut(MemDataOut), .Moc(Moc)
  );

  // RAM model state and per-access log
  logic [7:0]  mem [0:255];
  logic [7:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic [1:0]  log_mode [0:255];
  logic        log_rw   [0:255];
  int          en_count = 0;
  int          hold = 0;
  int          hold_cfg = 0;
  logic        moc_dead = 1'b0;
  logic        inited = 1'b0;
  logic [7:0]  a;

  always @(negedge Clk) begin
    if (Reset) begin
      Moc  = 1'b0;
      hold = 0;
      if (!inited) begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        inited = 1'b1;
      end
    end else if (MemEnable) begin
      log_addr[en_count[7:0]] = MemAddress;
      log_data[en_count[7:0]] = MemDataIn;
      log_mode[en_count[7:0]] = MemMode;
      log_rw[en_count[7:0]]   = MemReadWrite;
      en_count++;
      a = MemAddress;
      if (MemReadWrite) begin
        case (MemMode)
          2'b00:   MemDataOut = {24'h0, mem[a]};
          2'b01:   MemDataOut = {16'h0, mem[a], mem[a+8'd1]};
          default: MemDataOut = {mem[a], mem[a+8'd1], mem[a+8'd2], mem[a+8'd3]};
        endcase
      end else begin
        case (MemMode)
          2'b00: mem[a] = MemDataIn[7:0];
          2'b01: begin
            mem[a] = MemDataIn[15:8]; mem[a+8'd1] = MemDataIn[7:0];
          end
          default: begin
            mem[a]      = MemDataIn[31:24]; mem[a+8'd1] = MemDataIn[23:16];
            mem[a+8'd2] = MemDataIn[15:8];  mem[a+8'd3] = MemDataIn[7:0];
          end
        endcase
      end
      Moc  = !moc_dead;
      hold = hold_cfg;
    end else if (hold > 0) begin
      hold--;
      Moc = 1'b1;
    end else begin
      Moc = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; returns cycles from acceptance to Done, Err/RData at Done,
  // and the RAM log index where this request's accesses start.
  task automatic do_req(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [7:0] addr, input logic [63:0] wdata, input bit poke,
                        output int lat, output logic err, output logic [63:0] rd,
                        output int e0);
    @(negedge Clk);
    Req = 1'b1; Rw = rw; Size = size; Signed = sgn; Addr = addr; WData = wdata;
    e0 = en_count;
    @(posedge Clk);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      Req = poke && (lat == 2);
      if (poke && lat == 2) begin
        Rw = 1'b0; Size = 2'b00; Addr = 8'h40; WData = 64'h77;
      end
    end while (!Done && lat < 100);
    Req = 1'b0;
    err = Err;
    rd  = RData;
  endtask

  int          lat, e0;
  logic        err;
  logic [63:0] rd;

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", {63'h0, Busy}, 64'h0);
    check("rst_done", {63'h0, Done}, 64'h0);
    check("rst_err",  {63'h0, Err},  64'h0);
    check("rst_rdata", RData, 64'h0);
    check("rst_en",   {63'h0, MemEnable}, 64'h0);
    check("rst_rw",   {63'h0, MemReadWrite}, 64'h1);
    check("rst_addr", {56'h0, MemAddress}, 64'h0);
    check("rst_din",  {32'h0, MemDataIn}, 64'h0);
    check("rst_mode", {62'h0, MemMode}, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // word store then signed word load
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 64'h0000_0000_DEAD_BEEF, 1'b0, lat, err, rd, e0);
    check("sw_lat", 64'(lat), 64'd3);
    check("sw_err", {63'h0, err}, 64'h0);
    check("sw_n", 64'(en_count - e0), 64'd1);
    check("sw_mode", {62'h0, log_mode[e0[7:0]]}, 64'h2);
    check("sw_rw", {63'h0, log_rw[e0[7:0]]}, 64'h0);
    check("sw_addr", {56'h0, log_addr[e0[7:0]]}, 64'h10);
    check("sw_din", {32'h0, log_data[e0[7:0]]}, 64'hDEADBEEF);
    do_req(1'b1, 2'b10, 1'b1, 8'h10, 64'h0, 1'b0, lat, err, rd, e0);
    check("lw_lat", 64'(lat), 64'd3);
    check("lw_mode", {62'h0, log_mode[e0[7:0]]}, 64'h2);
    check("lw_rw", {63'h0, log_rw[e0[7:0]]}, 64'h1);
    check("lw_err", {63'h0, err}, 64'h0);
    check("lw_data", rd, 64'hFFFFFFFF_DEADBEEF);

    // byte and half loads, both extensions
    do_req(1'b1, 2'b00, 1'b0, 8'h10, 64'h0, 1'b0, lat, err, rd, e0);
    check("lbu", rd, 64'h00000000_000000DE);
    check("lbu_mode", {62'h0, log_mode[e0[7:0]]}, 64'h0);
    do_req(1'b1, 2'b00, 1'b1, 8'h10, 64'h0, 1'b0, lat, err, rd, e0);
    check("lbs", rd, 64'hFFFFFFFF_FFFFFFDE);
    do_req(1'b1, 2'b01, 1'b1, 8'h12, 64'h0, 1'b0, lat, err, rd, e0);
    check("lhs", rd, 64'hFFFFFFFF_FFFFBEEF);
    check("lhs_mode", {62'h0, log_mode[e0[7:0]]}, 64'h1);
    do_req(1'b1, 2'b01, 1'b0, 8'h12, 64'h0, 1'b0, lat, err, rd, e0);
    check("lhu", rd, 64'h00000000_0000BEEF);

    // dword store and load
    do_req(1'b0, 2'b11, 1'b0, 8'h20, 64'h01234567_89ABCDEF, 1'b0, lat, err, rd, e0);
    check("sd_lat", 64'(lat), 64'd5);
    check("sd_n", 64'(en_count - e0), 64'd2);
    check("sd_a0", {56'h0, log_addr[e0[7:0]]}, 64'h20);
    check("sd_a1", {56'h0, log_addr[8'(e0 + 1)]}, 64'h24);
    check("sd_d0", {32'h0, log_data[e0[7:0]]}, 64'h01234567);
    check("sd_d1", {32'h0, log_data[8'(e0 + 1)]}, 64'h89ABCDEF);
    check("sd_m1", {62'h0, log_mode[8'(e0 + 1)]}, 64'h2);
    do_req(1'b1, 2'b11, 1'b1, 8'h20, 64'h0, 1'b0, lat, err, rd, e0);
    check("ld_lat", 64'(lat), 64'd5);
    check("ld_data", rd, 64'h01234567_89ABCDEF);

    // misaligned requests
    do_req(1'b1, 2'b01, 1'b0, 8'h11, 64'h0, 1'b0, lat, err, rd, e0);
    check("mis_h_lat", 64'(lat), 64'd1);
    check("mis_h_err", {63'h0, err}, 64'h1);
    check("mis_h_n", 64'(en_count - e0), 64'd0);
    check("mis_h_rd", rd, 64'h01234567_89ABCDEF);
    do_req(1'b1, 2'b11, 1'b0, 8'h24, 64'h0, 1'b0, lat, err, rd, e0);
    check("mis_d_err", {63'h0, err}, 64'h1);
    do_req(1'b1, 2'b10, 1'b0, 8'h12, 64'h0, 1'b0, lat, err, rd, e0);
    check("mis_w_err", {63'h0, err}, 64'h1);

    // byte store uses only low lane; RData untouched by stores
    do_req(1'b0, 2'b00, 1'b0, 8'h30, 64'hFFFFFFFF_FFFFFFA5, 1'b0, lat, err, rd, e0);
    check("sb_din", {32'h0, log_data[e0[7:0]]}, 64'h000000A5);
    check("sb_mode", {62'h0, log_mode[e0[7:0]]}, 64'h0);
    check("sb_rd", rd, 64'h01234567_89ABCDEF);
    check("sb_err", {63'h0, err}, 64'h0);
    do_req(1'b1, 2'b00, 1'b1, 8'h30, 64'h0, 1'b0, lat, err, rd, e0);
    check("lb_a5", rd, 64'hFFFFFFFF_FFFFFFA5);

    // Moc held three cycles into RELEASE, with a Req poke while busy
    hold_cfg = 3;
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 64'h0, 1'b1, lat, err, rd, e0);
    hold_cfg = 0;
    check("hold_lat", 64'(lat), 64'd6);
    check("hold_n", 64'(en_count - e0), 64'd1);
    check("hold_rd", rd, 64'h00000000_DEADBEEF);
    @(negedge Clk);
    check("poke_busy", {63'h0, Busy}, 64'h0);
    do_req(1'b1, 2'b00, 1'b0, 8'h40, 64'h0, 1'b0, lat, err, rd, e0);
    check("poke_mem", rd, 64'h0);

    // highest aligned dword
    do_req(1'b0, 2'b11, 1'b0, 8'hF8, 64'hAAAA5555_0F0F0F0F, 1'b0, lat, err, rd, e0);
    check("top_a1", {56'h0, log_addr[8'(e0 + 1)]}, 64'hFC);
    do_req(1'b1, 2'b11, 1'b0, 8'hF8, 64'h0, 1'b0, lat, err, rd, e0);
    check("top_ld", rd, 64'hAAAA5555_0F0F0F0F);

    // reset during second half of a dword store
    @(negedge Clk);
    Req = 1'b1; Rw = 1'b0; Size = 2'b11; Addr = 8'h50; WData = 64'h11112222_33334444;
    @(posedge Clk);
    @(negedge Clk); Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("mid_en", {63'h0, MemEnable}, 64'h1);
    check("mid_addr", {56'h0, MemAddress}, 64'h54);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rr_en", {63'h0, MemEnable}, 64'h0);
    check("rr_busy", {63'h0, Busy}, 64'h0);
    check("rr_done", {63'h0, Done}, 64'h0);
    check("rr_rd", RData, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    do_req(1'b1, 2'b10, 1'b0, 8'h50, 64'h0, 1'b0, lat, err, rd, e0);
    check("part_hi", rd, 64'h00000000_11112222);
    do_req(1'b1, 2'b10, 1'b0, 8'h54, 64'h0, 1'b0, lat, err, rd, e0);
    check("part_lo", rd, 64'h00000000_33334444);

`ifdef MEM_TIMEOUT_EN
    moc_dead = 1'b1;
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 64'h0, 1'b0, lat, err, rd, e0);
    moc_dead = 1'b0;
    check("tmo_lat", 64'(lat), 64'd16);
    check("tmo_err", {63'h0, err}, 64'h1);
    check("tmo_n", 64'(en_count - e0), 64'd15);
    check("tmo_rd", rd, 64'h00000000_33334444);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side memory access controller that sits directly upstream of the 256x8 byte-addressable RAM. It accepts one load/store request at a time from the datapath and checks alignment. It drives the RAM's Enable/ReadWrite/Address/DataIn/Mode lines and waits on the RAM's MOC handshake. It splits doubleword transfers into two word accesses and returns sign- or zero-extended load data with a one-cycle Done pulse.

Parameters:
ADDR_W, 8, RAM byte-address width.
MOC_TIMEOUT, 15, maximum cycles spent in ACCESS waiting for Moc; applies only with MEM_TIMEOUT_EN.

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Req  in  1  request strobe, sampled only in IDLE
Rw  in  1  1=load (read), 0=store (write)
Size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
Signed  in  1  loads only: 1 sign-extend, 0 zero-extend
Addr  in  ADDR_W  byte address of request
WData  in  64  store data; byte/half/word use low bits, dword uses all 64
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse
Err  out  1  valid with Done: misalignment (or timeout)
RData  out  64  load result, held until next load completes
MemEnable  out  1  to RAM Enable
MemReadWrite  out  1  to RAM ReadWrite (1=read)
MemAddress  out  ADDR_W  to RAM Address
MemDataIn  out  32  to RAM DataIn
MemMode  out  2  to RAM Mode; only 00/01/10 are ever driven
MemDataOut  in  32  from RAM DataOut
Moc  in  1  from RAM, memory operation complete

Behaviour:
- Reset values: Busy=0, Done=0, Err=0, RData=0, MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataIn=0, MemMode=00; state=IDLE.
- Reset asserted mid-operation: all of the above on the next edge, with MemEnable dropping immediately. A partial dword store is not rolled back.
- States: IDLE, ACCESS, RELEASE, FINISH.
- IDLE: on Req=1, latch Rw/Size/Signed/Addr/WData and check alignment.
  - Alignment rules: half needs Addr[0]=0, word needs Addr[1:0]=0, dword needs Addr[2:0]=0.
  - Misaligned: go to FINISH with Err=1; no RAM access is issued.
  - Aligned: go to ACCESS.
- Req while Busy=1 is ignored; it is not queued.
- ACCESS: MemEnable=1; MemReadWrite=Rw; MemAddress=current address.
  - MemMode=Size for byte/half/word; MemMode=10 for each dword half.
  - Store data on MemDataIn: byte WData[7:0] in [7:0]; half WData[15:0] in [15:0]; word WData[31:0]; dword first half WData[63:32], second half WData[31:0]. Unused bits are 0.
  - Stay in ACCESS until Moc=1 is sampled. On that edge, capture MemDataOut if loading, then go to RELEASE.
- RELEASE: MemEnable=0; wait until Moc=0 is sampled.
  - If this is the first half of a dword: address += 4, go to ACCESS.
  - Otherwise: go to FINISH.
- FINISH: Done=1 for exactly one cycle, Busy still 1, then IDLE. Err is low except for misalignment or timeout.
- Load result formatting:
  - byte: MemDataOut[7:0] extended to 64 bits per Signed.
  - half: MemDataOut[15:0] extended to 64 bits per Signed.
  - word: MemDataOut[31:0] extended to 64 bits per Signed.
  - dword: first word to RData[63:32], second word to RData[31:0]; Signed is ignored.
- RData updates only on the FINISH of a successful load. Stores and errors leave it unchanged.
- Latency from the accepting edge with Moc high during the first ACCESS cycle and low during the first RELEASE cycle:
  - Done high 3 cycles after acceptance for single accesses.
  - Done high 5 cycles after acceptance for dwords.
  - Misaligned requests: Done 1 cycle after acceptance.
- Address arithmetic is modulo 2^ADDR_W. An aligned dword never wraps (max second address 252).

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter runs in ACCESS. If Moc is still 0 after MOC_TIMEOUT consecutive ACCESS cycles, the controller drops MemEnable, goes to FINISH with Err=1, and leaves RData unchanged. The counter clears on every ACCESS entry.
- Undefined: ACCESS waits indefinitely and Err signals misalignment only.

Test Plan:
- Store word 32'hDEADBEEF at Addr 8'h10, then load word at 8'h10 with Signed=1 -> MemMode=10 on both; RData=64'hFFFFFFFF_DEADBEEF, Err=0.
- Load byte at 8'h10 with Signed=0 after RAM byte 8'h10=8'hDE -> RData=64'h00000000_000000DE; with Signed=1 -> 64'hFFFFFFFF_FFFFFFDE.
- Store dword 64'h01234567_89ABCDEF at 8'h20 -> two ACCESS phases at MemAddress 8'h20 then 8'h24 with MemDataIn 32'h01234567 then 32'h89ABCDEF; dword load returns the same 64-bit value with Done 5 cycles after acceptance (single-cycle Moc).
- Half load at 8'h11 -> Done+Err one cycle after acceptance, MemEnable never asserted, RData unchanged.
- Hold Moc=1 into RELEASE for 3 cycles -> MemEnable stays 0, FINISH is delayed until Moc=0; a Req pulse during Busy is ignored.
- Assert Reset during the second half of a dword store -> next edge MemEnable=0, Busy=0, Done=0. With MEM_TIMEOUT_EN and Moc tied 0 -> Err+Done after 15 ACCESS cycles.
